// File: rtl/sub_bist_pkg.sv
// Shared types and golden borrow-subtractor function for the subtractor-cell BIST.
package sub_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_e;

  localparam int VEC_W   = 5;
  localparam int NUM_VEC = 8;

  // Returns {s, cout} for a - b - cin with cin/cout acting as borrow.
  function automatic logic [1:0] sub_golden(input logic [2:0] abc);
    logic a, b, c;
    {a, b, c} = abc;
    return {a ^ b ^ c, (~a & b) | (~(a ^ b) & c)};
  endfunction

endpackage

// File: rtl/sub_ref_model.sv
// Combinational golden 1-bit full subtractor; kept standalone so other blocks can reuse it.
module sub_ref_model
  import sub_bist_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign {s_o, cout_o} = sub_golden({a_i, b_i, cin_i});

endmodule

// File: rtl/sub_bist.sv
// Exhaustive self-test sequencer for the 1-bit subtractor cell: drives all 8 vectors,
// checks responses, and reports error count, pass/fail and the first failing vector.
module sub_bist
  import sub_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_i,
  input  logic             cout_i,
  output logic             a_o,
  output logic             b_o,
  output logic             cin_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       err_q;
  logic             fv_q;
  logic [VEC_W-1:0] fvec_q;

  logic       s_exp, cout_exp;
  logic       mismatch;
  logic [3:0] err_d;

  sub_ref_model u_ref (
    .a_i    (idx_q[2]),
    .b_i    (idx_q[1]),
    .cin_i  (idx_q[0]),
    .s_o    (s_exp),
    .cout_o (cout_exp)
  );

  assign mismatch = ({s_i, cout_i} != {s_exp, cout_exp});
  assign err_d    = err_q + {3'b000, mismatch};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          if (SETTLE_CYCLES > 0) begin
            cnt_q   <= SETTLE - 3'd1;
            state_q <= WAIT;
          end else begin
            state_q <= CHECK;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) state_q <= CHECK;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !fv_q) begin
            fv_q   <= 1'b1;
            fvec_q <= {idx_q, s_i, cout_i};
          end
          // pass is resolved here so it is already valid during the done pulse
          if (idx_q == 3'(NUM_VEC - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= APPLY;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {a_o, b_o, cin_o} = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: doc/sub_bist.md
# sub_bist

Built-in self-test controller for the 1-bit full subtractor cell (`sub`) of the MIPS datapath. It generates the exhaustive 8-entry stimulus set {a, b, cin} in hardware and drives it into the cell. It compares the cell's `s`/`cout` against a golden model, then reports an error count, pass/fail, and the first failing vector. The vector format is {a, b, cin, s, cout}, the same format as the subtractor vector file. The block sits beside the subtractor, under a test-mode mux in the ALU.

## Interface
- `SETTLE_CYCLES`, default 1: wait cycles between applying a vector and sampling the response; legal range 0..7.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run one test pass; ignored unless the block is idle.
- `a_o`, `b_o`, `cin_o`  out  1 each  stimulus to the subtractor cell.
- `s_i`, `cout_i`  in  1 each  response from the subtractor cell.
- `busy`  out  1  high from the first cycle of APPLY through the last CHECK.
- `done`  out  1  one-cycle pulse when the pass completes.
- `pass`  out  1  `err_count == 0`; valid from `done` until the next `start`.
- `err_count`  out  4  number of mismatching vectors, range 0..8.
- `fail_valid`  out  1  at least one mismatch occurred in this pass.
- `fail_vec`  out  5  first mismatch as {a, b, cin, s_observed, cout_observed}.

## Operation
- Golden model: `s_exp = a ^ b ^ cin`; `cout_exp = (~a & b) | (~(a ^ b) & cin)`. This is a − b − cin with cin/cout as borrow.
- Vector index `idx` is 3 bits; {a, b, cin} = idx[2:0], with a as the MSB. Vectors run in order 0..7.
- States:
  - IDLE: when `start` is high, clear `err_count`, `fail_valid`, `fail_vec` and `pass`, set `idx` = 0, go to APPLY.
  - APPLY: drive the vector for one cycle. Go to WAIT if `SETTLE_CYCLES` > 0, else go to CHECK.
  - WAIT: count `SETTLE_CYCLES` cycles, then go to CHECK.
  - CHECK: compare `s_i`/`cout_i` to the expected values.
    - On mismatch, increment `err_count`. If `fail_valid` is 0, capture `fail_vec` and set `fail_valid`.
    - If `idx` == 7, go to DONE. Otherwise increment `idx` and go to APPLY.
  - DONE: assert `done` for one cycle, update `pass`, go to IDLE.
- `a_o`/`b_o`/`cin_o` hold the current vector from APPLY through CHECK. They hold the last value in IDLE and DONE.
- `start` in any state other than IDLE is ignored and not queued.
- `err_count` cannot overflow because there are at most 8 mismatches.

## Timing
- Reset values: state IDLE, `idx` 0, `a_o`/`b_o`/`cin_o` 0, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `fail_valid` 0, `fail_vec` 0.
- Reset asserted mid-pass aborts the pass immediately: all outputs return to their reset values and no `done` is produced.
- Per-vector time is S + 2 cycles, where S = `SETTLE_CYCLES`.
- If `start` is sampled at edge k, then:
  - APPLY of vector v begins at cycle k+1+v·(S+2).
  - `done` is high in cycle k+1+8·(S+2); for S = 1 that is cycle k+25.
- `s_i`/`cout_i` are sampled at the rising edge that ends the CHECK cycle. The response path is combinational; S covers registered or slow test models.
- A `start` arriving in the same cycle as `done` is ignored. The next pass needs `start` high while in IDLE.

## Structure
- Package `sub_bist_pkg`:
  - state enum (IDLE, APPLY, WAIT, CHECK, DONE)
  - `VEC_W` = 5, `NUM_VEC` = 8
  - a function returning {s_exp, cout_exp} from {a, b, cin}
- One sub-module, `sub_ref_model`: the combinational golden subtractor. It is instantiated once and is separate so the bench can reuse it.
- The top level contains the FSM, the idx and settle counters, and the result registers.

## Test plan
- Correct cell, S = 1, start at cycle 0: `done` at cycle 25; `err_count` = 0, `pass` = 1, `fail_valid` = 0.
- `s` stuck at 0: `err_count` = 4, `pass` = 0, `fail_vec` = 5'b00101 (vector idx 1).
- `cout` inverted: `err_count` = 8, `fail_vec` = 5'b00001 (idx 0).
- `start` pulsed again during WAIT of vector 3: no restart; `done` stays at cycle 25 and results are unchanged.
- `rst` low during CHECK of vector 5: all outputs go to 0 and no `done`; a following `start` runs a full clean pass.
- S = 3 with a one-cycle registered cell model: `done` at cycle 41 and `err_count` = 0. S = 0 with the same model gives `err_count` > 0.
